// File: rtl/dct_transpose_buffer_pkg.sv
// Shared constants, read-FSM state type and addressing helper for the 8x8 DCT
// transpose buffer.
package dct_transpose_buffer_pkg;

    localparam int DCT_N   = 8;            // block edge length
    localparam int DCT_BLK = DCT_N * DCT_N; // samples per block
    localparam int IDX_W   = 6;            // index width within a block
    localparam int RC_W    = 3;            // row/column index width

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Map a column-major read count onto the row-major storage index:
    // row = cnt % 8, col = cnt / 8, stored at row*8 + col.
    function automatic logic [IDX_W-1:0] col_major_addr(input logic [IDX_W-1:0] cnt);
        return {cnt[RC_W-1:0], cnt[IDX_W-1:RC_W]};
    endfunction

endpackage

// File: rtl/dct_transpose_buffer_if.sv
// Streaming bus of the DCT transpose buffer: row-major samples in, column-major
// samples out. Block_Count exists only when DCT_TRANSPOSE_BLKCNT_EN is defined.
interface dct_transpose_buffer_if #(
    parameter int WIDTH = 10
);
    logic             En_In;
    logic [WIDTH-1:0] Data_In;
    logic             En_Out;
    logic [WIDTH-1:0] Data_Out;
    logic             Block_Start;
`ifdef DCT_TRANSPOSE_BLKCNT_EN
    logic [15:0]      Block_Count;

    // Design side
    modport slave (
        input  En_In, Data_In,
        output En_Out, Data_Out, Block_Start, Block_Count
    );

    // Environment side (producer and consumer)
    modport master (
        output En_In, Data_In,
        input  En_Out, Data_Out, Block_Start, Block_Count
    );
`else
    // Design side
    modport slave (
        input  En_In, Data_In,
        output En_Out, Data_Out, Block_Start
    );

    // Environment side (producer and consumer)
    modport master (
        output En_In, Data_In,
        input  En_Out, Data_Out, Block_Start
    );
`endif

endinterface

// File: rtl/dct_transpose_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// Array contents are not reset; only the read register is cleared.
module dct_transpose_ram #(
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Write port
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column 1-D DCT passes.
// One bank fills in row-major order while the other drains in column-major order.
// Optional feature: define DCT_TRANSPOSE_BLKCNT_EN to add the Block_Count output.
module dct_transpose_buffer
    import dct_transpose_buffer_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input logic                  Clock,
    input logic                  Reset,
    dct_transpose_buffer_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DCT_BLK - 1);

    logic [IDX_W-1:0] wr_idx;
    logic             wr_bank;
    logic             wr_done;

    rd_state_t        state;
    logic [IDX_W-1:0] rd_cnt;
    logic             rd_bank;
    logic [1:0]       full;
    logic             rd_last;
    logic             other_full;

    logic             en_out;
    logic             block_start;
    logic [WIDTH-1:0] rd_data;

    assign wr_done = bus.En_In && (wr_idx == LAST_IDX);
    assign rd_last = (state == READ) && (rd_cnt == LAST_IDX);

    // A block completing in this very cycle counts as ready, so a write-limited
    // stream keeps the output burst free of bubbles.
    assign other_full = full[~rd_bank] || (wr_done && (wr_bank != rd_bank));

    // Write side: row-major index and bank toggle at block end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else if (bus.En_In) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == LAST_IDX) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read FSM with bank-full flags and registered output strobes
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            en_out      <= 1'b0;
            block_start <= 1'b0;
        end else begin
            // Set and clear never target the same flag in one cycle.
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
            end
            en_out      <= (state == READ);
            block_start <= (state == READ) && (rd_cnt == '0);
            case (state)
                IDLE: begin
                    rd_cnt <= '0;
                    if (full[rd_bank]) begin
                        state <= READ;
                    end
                end
                READ: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_last) begin
                        full[rd_bank] <= 1'b0;
                        rd_bank       <= ~rd_bank;
                        if (!other_full) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dct_transpose_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (IDX_W + 1)
    ) u_ram (
        .clock   (Clock),
        .reset   (Reset),
        .wr_en   (bus.En_In),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data (bus.Data_In),
        .rd_en   (state == READ),
        .rd_addr ({rd_bank, col_major_addr(rd_cnt)}),
        .rd_data (rd_data)
    );

    assign bus.En_Out      = en_out;
    assign bus.Data_Out    = rd_data;
    assign bus.Block_Start = block_start;

`ifdef DCT_TRANSPOSE_BLKCNT_EN
    logic        last_out;
    logic [15:0] blk_cnt;

    // Count completed output blocks, stepping the cycle after the last En_Out
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_out <= 1'b0;
            blk_cnt  <= '0;
        end else begin
            last_out <= rd_last;
            if (last_out) begin
                blk_cnt <= blk_cnt + 16'd1;
            end
        end
    end

    assign bus.Block_Count = blk_cnt;
`endif

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed self-checking bench for dct_transpose_buffer.
// Block_Count checks are compiled in when DCT_TRANSPOSE_BLKCNT_EN is defined.
module tb_dct_transpose_buffer;

    localparam int W = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int in_cnt   = 0;
    int last_acc = 0;

    int oq [$];
    int cq [$];
    bit bq [$];
    int blk [2][64];

    dct_transpose_buffer_if #(.WIDTH(W)) bus ();

    dct_transpose_buffer #(.WIDTH(W)) dut (
        .Clock (clock),
        .Reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Cycle count and edge at which each block's 64th sample is accepted
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            in_cnt = 0;
        end else if (bus.En_In === 1'b1) begin
            in_cnt++;
            if (in_cnt % 64 == 0) last_acc = cyc;
        end
    end

    // Output capture on the falling edge
    always @(negedge clock) begin
        if (bus.En_Out === 1'b1) begin
            oq.push_back(int'($signed(bus.Data_Out)));
            cq.push_back(cyc);
            bq.push_back(bus.Block_Start);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic feed_n(input int sel, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            bus.En_In   = 1'b1;
            bus.Data_In = W'(blk[sel][i]);
            for (int g = 0; g < gap; g++) begin
                @(posedge clock);
                #1;
                bus.En_In = 1'b0;
            end
        end
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        bus.En_In = 1'b0;
    endtask

    task automatic clear_q();
        oq.delete();
        cq.delete();
        bq.delete();
    endtask

    task automatic wait_out(input string tag, input int n);
        int k = 0;
        while (oq.size() < n && k < 400) begin
            @(negedge clock);
            k++;
        end
        repeat (6) @(negedge clock);
        chk({tag, "_count"}, oq.size(), n);
    endtask

    // Column-major golden order: output k is input (k%8)*8 + k/8
    task automatic chk_block(input string tag, input int sel, input int off);
        int bs_rest = 0;
        if (oq.size() < off + 64) begin
            chk({tag, "_short"}, oq.size(), off + 64);
            return;
        end
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("%s_d%0d", tag, k), oq[off + k], blk[sel][(k % 8) * 8 + k / 8]);
            if (k > 0) bs_rest += int'(bq[off + k]);
        end
        chk({tag, "_bs_first"}, int'(bq[off]), 1);
        chk({tag, "_bs_rest"}, bs_rest, 0);
        chk({tag, "_contig"}, cq[off + 63] - cq[off], 63);
    endtask

    initial begin
        bus.En_In   = 1'b0;
        bus.Data_In = '0;
        reset       = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_en_out", int'(bus.En_Out), 0);
        chk("rst_data_out", int'(bus.Data_Out), 0);
        chk("rst_block_start", int'(bus.Block_Start), 0);
`ifdef DCT_TRANSPOSE_BLKCNT_EN
        chk("rst_block_count", int'(bus.Block_Count), 0);
`endif
        reset = 1'b0;

        // Single contiguous block 0..63
        for (int i = 0; i < 64; i++) blk[0][i] = i;
        clear_q();
        feed_n(0, 64, 0);
        idle();
        wait_out("s1", 64);
        chk_block("s1", 0, 0);
        if (oq.size() >= 64) begin
            chk("s1_lat", cq[0] - last_acc, 2);
            chk("s1_k1", oq[1], 8);
            chk("s1_k8", oq[8], 1);
            chk("s1_k63", oq[63], 63);
        end

        // Back-to-back blocks 0..63 then 100..163
        for (int i = 0; i < 64; i++) begin
            blk[0][i] = i;
            blk[1][i] = 100 + i;
        end
        clear_q();
        feed_n(0, 64, 0);
        feed_n(1, 64, 0);
        idle();
        wait_out("s2", 128);
        chk_block("s2a", 0, 0);
        chk_block("s2b", 1, 64);
        if (oq.size() >= 128) begin
            chk("s2_nobubble", cq[64] - cq[63], 1);
            chk("s2b_k1", oq[65], 108);
        end

        // Gapped input, one sample every third cycle, negative values
        for (int i = 0; i < 64; i++) blk[0][i] = -512 + i;
        clear_q();
        feed_n(0, 64, 2);
        idle();
        wait_out("s3", 64);
        chk_block("s3", 0, 0);
        if (oq.size() >= 64) begin
            chk("s3_lat", cq[0] - last_acc, 2);
            chk("s3_k1", oq[1], -504);
        end

        // Reset while a burst drains and a second block is partially written
        for (int i = 0; i < 64; i++) begin
            blk[0][i] = i;
            blk[1][i] = 300 + i;
        end
        clear_q();
        feed_n(0, 64, 0);
        feed_n(1, 30, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("s4_burst_active", int'(oq.size() > 0), 1);
        chk("s4_en_out_async", int'(bus.En_Out), 0);
        bus.En_In = 1'b0;
        @(posedge clock);
        #1;
        chk("s4_en_out_rst", int'(bus.En_Out), 0);
        reset = 1'b0;
        clear_q();
        repeat (100) @(posedge clock);
        chk("s4_no_partial", oq.size(), 0);
        feed_n(0, 64, 0);
        idle();
        wait_out("s4", 64);
        chk_block("s4", 0, 0);

        // Extremes: alternating +511 / -512
        for (int i = 0; i < 64; i++) blk[0][i] = (i % 2 == 0) ? 511 : -512;
        clear_q();
        feed_n(0, 64, 0);
        idle();
        wait_out("s5", 64);
        chk_block("s5", 0, 0);
        if (oq.size() >= 64) begin
            chk("s5_k8", oq[8], -512);
            chk("s5_k9", oq[9], -512);
        end

`ifdef DCT_TRANSPOSE_BLKCNT_EN
        // Block counter: three blocks, then wrap from 65535
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            for (int i = 0; i < 64; i++) blk[0][i] = b * 64 + i - 256;
            clear_q();
            feed_n(0, 64, 0);
            idle();
            wait_out($sformatf("bc%0d", b), 64);
            chk($sformatf("bc%0d_val", b), int'(bus.Block_Count), b);
        end
        @(negedge clock);
        force dut.blk_cnt = 16'hFFFF;
        @(negedge clock);
        release dut.blk_cnt;
        clear_q();
        feed_n(0, 64, 0);
        idle();
        wait_out("bcwrap", 64);
        chk("bcwrap_val", int'(bus.Block_Count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
